// File: rtl/ddr2_wr_data_sequencer.sv
// DDR2 write-data/mask sequencer on clk90. User words are buffered in a small
// FIFO. An accepted write command waits the programmed write latency and then
// streams one rise/fall word per cycle to the DQ/DM IOBs. The IOB enables are
// raised only for the beats of the burst, and the masks idle at all ones.
module ddr2_wr_data_sequencer #(
  parameter int DQ_WIDTH   = 16,
  parameter int DM_WIDTH   = DQ_WIDTH / 8,
  parameter int FIFO_DEPTH = 16,
  parameter int WL_WIDTH   = 3
) (
  input  logic                        clk90,
  input  logic                        rst_n,
  input  logic [2*DQ_WIDTH-1:0]       wr_data_in,
  input  logic [2*DM_WIDTH-1:0]       wr_mask_in,
  input  logic                        wr_valid,
  output logic                        wr_ready,
  input  logic                        wr_cmd,
  input  logic                        burst_len,
  input  logic [WL_WIDTH-1:0]         write_latency,
  output logic                        cmd_ready,
  output logic [DQ_WIDTH-1:0]         wr_data_rise,
  output logic [DQ_WIDTH-1:0]         wr_data_fall,
  output logic [DM_WIDTH-1:0]         mask_data_rise,
  output logic [DM_WIDTH-1:0]         mask_data_fall,
  output logic                        dm_wr_en,
  output logic                        dq_wr_en,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 2*DQ_WIDTH + 2*DM_WIDTH;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [WW-1:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q, count_d;
  logic                ready_en_q;
  logic [1:0]          state_q, state_d;
  logic [WL_WIDTH-1:0] wl_cnt_q, wl_cnt_d;
  logic [1:0]          beat_cnt_q, beat_cnt_d;
  logic                bl8_q, bl8_d;

  logic [DQ_WIDTH-1:0] data_rise_q, data_fall_q;
  logic [DM_WIDTH-1:0] mask_rise_q, mask_fall_q;
  logic                wr_en_q;

  logic [CW-1:0]       cmd_beats;
  logic                accept;
  logic                push;
  logic                pop;
  logic [WW-1:0]       head_word;

  // Handshakes: the FIFO takes a word when it has room, and a command is taken
  // only from IDLE once the whole burst is already buffered, so it cannot underrun.
  always_comb begin
    cmd_beats = burst_len ? CW'(4) : CW'(2);
    wr_ready  = ready_en_q && (count_q < DEPTH_C);
    cmd_ready = (state_q == ST_IDLE) && (count_q >= cmd_beats);
    accept    = wr_cmd && cmd_ready;
    push      = wr_valid && wr_ready;
    pop       = (state_q == ST_BURST);
    head_word = mem_q[rd_ptr_q];
  end

  // Occupancy follows push/pop; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Write-path FSM: IDLE -> (WAIT for the write latency) -> BURST for 2 or 4 beats.
  always_comb begin
    state_d    = state_q;
    wl_cnt_d   = wl_cnt_q;
    beat_cnt_d = beat_cnt_q;
    bl8_d      = bl8_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          bl8_d = burst_len;
          if (write_latency == '0) begin
            state_d    = ST_BURST;
            beat_cnt_d = burst_len ? 2'd3 : 2'd1;
          end else begin
            state_d  = ST_WAIT;
            wl_cnt_d = write_latency;
          end
        end
      end
      ST_WAIT: begin
        wl_cnt_d = wl_cnt_q - WL_WIDTH'(1);
        if (wl_cnt_q == WL_WIDTH'(1)) begin
          state_d    = ST_BURST;
          beat_cnt_d = bl8_q ? 2'd3 : 2'd1;
        end
      end
      ST_BURST: begin
        if (beat_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
        end else begin
          beat_cnt_d = beat_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO storage; it needs no reset because occupancy is tracked by the pointers.
  always_ff @(posedge clk90) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wr_mask_in, wr_data_in};
    end
  end

  // Control state, FIFO pointers and the post-reset write enable for the FIFO.
  always_ff @(posedge clk90 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
      state_q    <= ST_IDLE;
      wl_cnt_q   <= '0;
      beat_cnt_q <= '0;
      bl8_q      <= 1'b0;
    end else begin
      ready_en_q <= 1'b1;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q    <= count_d;
      state_q    <= state_d;
      wl_cnt_q   <= wl_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      bl8_q      <= bl8_d;
    end
  end

  // IOB output register: the popped word during BURST, otherwise a quiet, fully masked bus.
  always_ff @(posedge clk90 or negedge rst_n) begin
    if (!rst_n) begin
      data_rise_q <= '0;
      data_fall_q <= '0;
      mask_rise_q <= '1;
      mask_fall_q <= '1;
      wr_en_q     <= 1'b0;
    end else if (pop) begin
      data_rise_q <= head_word[DQ_WIDTH-1:0];
      data_fall_q <= head_word[2*DQ_WIDTH-1:DQ_WIDTH];
      mask_rise_q <= head_word[2*DQ_WIDTH+DM_WIDTH-1:2*DQ_WIDTH];
      mask_fall_q <= head_word[WW-1:2*DQ_WIDTH+DM_WIDTH];
      wr_en_q     <= 1'b1;
    end else begin
      data_rise_q <= '0;
      data_fall_q <= '0;
      mask_rise_q <= '1;
      mask_fall_q <= '1;
      wr_en_q     <= 1'b0;
    end
  end

  assign wr_data_rise   = data_rise_q;
  assign wr_data_fall   = data_fall_q;
  assign mask_data_rise = mask_rise_q;
  assign mask_data_fall = mask_fall_q;
  assign dm_wr_en       = wr_en_q;
  assign dq_wr_en       = wr_en_q;
  assign fifo_count     = count_q;

endmodule

// File: tb/tb_ddr2_wr_data_sequencer.sv
// Directed testbench for ddr2_wr_data_sequencer with hand-computed expectations.
module tb_ddr2_wr_data_sequencer;

  logic        clk90;
  logic        rst_n;
  logic [31:0] wr_data_in;
  logic [3:0]  wr_mask_in;
  logic        wr_valid;
  logic        wr_ready;
  logic        wr_cmd;
  logic        burst_len;
  logic [2:0]  write_latency;
  logic        cmd_ready;
  logic [15:0] wr_data_rise, wr_data_fall;
  logic [1:0]  mask_data_rise, mask_data_fall;
  logic        dm_wr_en, dq_wr_en;
  logic [4:0]  fifo_count;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  ddr2_wr_data_sequencer #(
    .DQ_WIDTH(16), .DM_WIDTH(2), .FIFO_DEPTH(16), .WL_WIDTH(3)
  ) dut (
    .clk90(clk90), .rst_n(rst_n),
    .wr_data_in(wr_data_in), .wr_mask_in(wr_mask_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_cmd(wr_cmd), .burst_len(burst_len), .write_latency(write_latency),
    .cmd_ready(cmd_ready),
    .wr_data_rise(wr_data_rise), .wr_data_fall(wr_data_fall),
    .mask_data_rise(mask_data_rise), .mask_data_fall(mask_data_fall),
    .dm_wr_en(dm_wr_en), .dq_wr_en(dq_wr_en),
    .fifo_count(fifo_count)
  );

  // Free-running clk90, rising edges at 5, 15, 25 ...
  initial clk90 = 1'b0;
  always #5 clk90 = ~clk90;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock edge with the given inputs; outputs are then sampled 1 ns after it.
  task automatic applyStimulus(input logic valid, input logic [15:0] fall,
                               input logic [15:0] rise, input logic [3:0] mask,
                               input logic cmd, input logic bl, input logic [2:0] wl);
    wr_valid      = valid;
    wr_data_in    = {fall, rise};
    wr_mask_in    = mask;
    wr_cmd        = cmd;
    burst_len     = bl;
    write_latency = wl;
    @(posedge clk90);
    #1;
    wr_valid = 1'b0;
    wr_cmd   = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk90);
    #1;
  endtask

  task automatic checkBeat(input string tag, input logic [15:0] fall,
                           input logic [15:0] rise, input logic [3:0] mask);
    checkOutput({tag, " data"}, {32'd0, wr_data_fall, wr_data_rise}, {32'd0, fall, rise});
    checkOutput({tag, " mask"}, {60'd0, mask_data_fall, mask_data_rise}, {60'd0, mask});
    checkOutput({tag, " en"}, {62'd0, dm_wr_en, dq_wr_en}, 64'd3);
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " data"}, {32'd0, wr_data_fall, wr_data_rise}, 64'd0);
    checkOutput({tag, " mask"}, {60'd0, mask_data_fall, mask_data_rise}, 64'hF);
    checkOutput({tag, " en"}, {62'd0, dm_wr_en, dq_wr_en}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_cmd = 1'b0; burst_len = 1'b0; write_latency = 3'd0;
    wr_data_in = '0; wr_mask_in = '0;

    // Reset values while rst_n is held low
    repeat (3) tick();
    checkIdle("reset");
    checkOutput("reset wr_ready", 64'(wr_ready), 64'd0);
    checkOutput("reset cmd_ready", 64'(cmd_ready), 64'd0);
    checkOutput("reset count", 64'(fifo_count), 64'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("wr_ready before first edge", 64'(wr_ready), 64'd0);
    tick();
    checkOutput("wr_ready after release", 64'(wr_ready), 64'd1);

    // BL4, WL=3
    applyStimulus(1'b1, 16'hBBBB, 16'hAAAA, 4'b0001, 1'b0, 1'b0, 3'd0);
    applyStimulus(1'b1, 16'hDDDD, 16'hCCCC, 4'b0000, 1'b0, 1'b0, 3'd0);
    checkOutput("bl4 count", 64'(fifo_count), 64'd2);
    checkOutput("bl4 cmd_ready", 64'(cmd_ready), 64'd1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 3'd3);
    checkIdle("bl4 T");
    checkOutput("bl4 cmd_ready in wait", 64'(cmd_ready), 64'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      checkIdle($sformatf("bl4 wait T+%0d", i));
    end
    tick();
    checkBeat("bl4 beat0", 16'hBBBB, 16'hAAAA, 4'b0001);
    tick();
    checkBeat("bl4 beat1", 16'hDDDD, 16'hCCCC, 4'b0000);
    checkOutput("bl4 count after", 64'(fifo_count), 64'd0);
    tick();
    checkIdle("bl4 after");

    // BL8, WL=0, with a push during the burst
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h2000 + 16'(i), 16'h1000 + 16'(i), 4'(i + 4), 1'b0, 1'b1, 3'd0);
    end
    checkOutput("bl8 count", 64'(fifo_count), 64'd4);
    checkOutput("bl8 cmd_ready", 64'(cmd_ready), 64'd1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 3'd0);
    checkIdle("bl8 T");
    applyStimulus(1'b1, 16'h6666, 16'h7777, 4'b1010, 1'b0, 1'b1, 3'd0);
    checkBeat("bl8 beat0", 16'h2000, 16'h1000, 4'd4);
    checkOutput("bl8 push+pop count", 64'(fifo_count), 64'd4);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkBeat($sformatf("bl8 beat%0d", i), 16'h2000 + 16'(i), 16'h1000 + 16'(i), 4'(i + 4));
    end
    checkOutput("bl8 count after", 64'(fifo_count), 64'd1);
    tick();
    checkIdle("bl8 after");

    // Insufficient data: one word buffered for a BL4 command
    burst_len = 1'b0;
    #1;
    checkOutput("short cmd_ready", 64'(cmd_ready), 64'd0);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 3'd0);
    tick();
    checkIdle("short ignored");
    checkOutput("short count", 64'(fifo_count), 64'd1);
    applyStimulus(1'b1, 16'h9999, 16'h8888, 4'b0110, 1'b0, 1'b0, 3'd0);
    checkOutput("short cmd_ready after push", 64'(cmd_ready), 64'd1);
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 3'd1);
    tick();
    checkIdle("wl1 wait");
    tick();
    checkBeat("wl1 beat0", 16'h6666, 16'h7777, 4'b1010);
    tick();
    checkBeat("wl1 beat1", 16'h9999, 16'h8888, 4'b0110);
    tick();
    checkIdle("wl1 after");
    checkOutput("wl1 count", 64'(fifo_count), 64'd0);

    // Fill to full, attempt an extra push, then drain with eight BL4 bursts
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 16'hE000 + 16'(i), 16'hF000 + 16'(i), 4'(i), 1'b0, 1'b0, 3'd0);
    end
    checkOutput("full count", 64'(fifo_count), 64'd16);
    checkOutput("full wr_ready", 64'(wr_ready), 64'd0);
    applyStimulus(1'b1, 16'hDEAD, 16'hBEEF, 4'hF, 1'b0, 1'b0, 3'd0);
    checkOutput("overflow count", 64'(fifo_count), 64'd16);
    for (int b = 0; b < 8; b++) begin
      checkOutput($sformatf("drain%0d cmd_ready", b), 64'(cmd_ready), 64'd1);
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 3'd0);
      for (int k = 0; k < 2; k++) begin
        tick();
        checkBeat($sformatf("drain%0d beat%0d", b, k),
                  16'hE000 + 16'(2*b + k), 16'hF000 + 16'(2*b + k), 4'(2*b + k));
      end
    end
    checkOutput("drain count", 64'(fifo_count), 64'd0);
    checkOutput("drain wr_ready", 64'(wr_ready), 64'd1);

    // Refill across the wrap and drain with two BL8 bursts at WL=2
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'hA500 + 16'(i), 16'h5A00 + 16'(i), ~4'(i), 1'b0, 1'b1, 3'd0);
    end
    for (int b = 0; b < 2; b++) begin
      applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 3'd2);
      repeat (2) tick();
      checkIdle($sformatf("wrap%0d wait", b));
      for (int k = 0; k < 4; k++) begin
        tick();
        checkBeat($sformatf("wrap%0d beat%0d", b, k),
                  16'hA500 + 16'(4*b + k), 16'h5A00 + 16'(4*b + k), ~4'(4*b + k));
      end
    end
    checkOutput("wrap count", 64'(fifo_count), 64'd0);

    // Reset asserted during the second beat of a BL8 burst
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 16'h3300 + 16'(i), 16'h4400 + 16'(i), 4'(i), 1'b0, 1'b1, 3'd0);
    end
    applyStimulus(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 3'd0);
    tick();
    checkBeat("rst beat0", 16'h3300, 16'h4400, 4'd0);
    tick();
    checkBeat("rst beat1", 16'h3301, 16'h4401, 4'd1);
    rst_n = 1'b0;
    #1;
    checkIdle("rst immediate");
    checkOutput("rst count", 64'(fifo_count), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkIdle($sformatf("post-rst %0d", i));
    end
    checkOutput("post-rst count", 64'(fifo_count), 64'd0);
    checkOutput("post-rst cmd_ready", 64'(cmd_ready), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
